// File: rtl/bp_xui_mem_model.sv
// Behavioral DRAM-controller model on the XUI/MIG app_* port with a block-wide internal array.
// Latency: read data returns rd_latency_p cycles after accept; writes land at the accept edge.
// Backpressure: app_rdy_o low during CALIB/REFRESH and at the read-credit cap; read returns cannot stall.
`timescale 1ns/1ps

module bp_xui_mem_model #(
  parameter int addr_width_p         = 40,
  parameter int data_width_p         = 512,
  parameter int mem_els_p            = 256,
  parameter int rd_latency_p         = 4,
  parameter int max_rd_outstanding_p = 2,
  parameter int refresh_period_p     = 64,
  parameter int refresh_cycles_p     = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,

  input  logic [addr_width_p-1:0]   app_addr_i,
  input  logic [2:0]                app_cmd_i,
  input  logic                      app_en_i,
  output logic                      app_rdy_o,

  input  logic                      app_wdf_wren_i,
  input  logic [data_width_p-1:0]   app_wdf_data_i,
  input  logic [data_width_p/8-1:0] app_wdf_mask_i,
  input  logic                      app_wdf_end_i,
  output logic                      app_wdf_rdy_o,

  output logic                      app_rd_data_valid_o,
  output logic [data_width_p-1:0]   app_rd_data_o,
  output logic                      app_rd_data_end_o,

  output logic                      init_calib_complete_o,
  output logic                      error_o
);

  localparam int mask_width_lp = data_width_p / 8;
  localparam int offset_lp     = $clog2(mask_width_lp);
  localparam int idx_width_lp  = $clog2(mem_els_p);
  localparam int ref_width_lp  = $clog2(refresh_period_p);
  localparam int cred_width_lp = $clog2(max_rd_outstanding_p + 1);

  localparam logic [2:0] cmd_wr_lp = 3'b000;
  localparam logic [2:0] cmd_rd_lp = 3'b001;

  localparam logic [idx_width_lp-1:0]  calib_last_lp   = idx_width_lp'(mem_els_p - 1);
  localparam logic [ref_width_lp-1:0]  ref_period_m1_lp = ref_width_lp'(refresh_period_p - 1);
  localparam logic [ref_width_lp-1:0]  ref_cycles_m1_lp = ref_width_lp'(refresh_cycles_p - 1);
  localparam logic [cred_width_lp-1:0] cred_max_lp      = cred_width_lp'(max_rd_outstanding_p);

  typedef enum logic [1:0] {
    e_calib   = 2'd0,
    e_ready   = 2'd1,
    e_refresh = 2'd2
  } state_e;

  state_e                    state_q;
  logic [idx_width_lp-1:0]   calib_cnt_q;
  logic [ref_width_lp-1:0]   refresh_cnt_q;
  logic                      init_calib_q;
  logic                      error_q, error_d;
  logic [cred_width_lp-1:0]  rd_out_q, rd_out_d;
  logic [rd_latency_p-1:0]   rd_vld_q;
  logic [rd_latency_p-1:0][data_width_p-1:0] rd_dat_q;

  // Block storage; contents survive reset and are cleared only by the CALIB walk.
  logic [data_width_p-1:0]   mem_q [mem_els_p];

  logic [idx_width_lp-1:0]   blk_idx;
  logic [data_width_p-1:0]   mem_rd_dat;
  logic                      cmd_acc;
  logic                      wr_cmd_acc;
  logic                      wr_acc;
  logic                      rd_acc;
  logic                      rd_ret;
  logic                      bad_cmd_acc;
  logic                      unused_addr_parity;

  // Only the block-index field of the byte address selects an entry.
  assign blk_idx            = app_addr_i[offset_lp +: idx_width_lp];
  assign unused_addr_parity = ^app_addr_i;
  assign mem_rd_dat         = mem_q[blk_idx];

  // Ready flags are functions of registered state only.
  assign app_rdy_o     = (state_q == e_ready) && (rd_out_q < cred_max_lp);
  assign app_wdf_rdy_o = (state_q == e_ready);

  assign cmd_acc     = app_en_i & app_rdy_o;
  assign wr_cmd_acc  = cmd_acc & (app_cmd_i == cmd_wr_lp);
  assign wr_acc      = wr_cmd_acc & app_wdf_wren_i & app_wdf_end_i;
  assign rd_acc      = cmd_acc & (app_cmd_i == cmd_rd_lp);
  assign bad_cmd_acc = cmd_acc & (app_cmd_i != cmd_wr_lp) & (app_cmd_i != cmd_rd_lp);
  assign rd_ret      = rd_vld_q[rd_latency_p-1];

  assign app_rd_data_valid_o   = rd_ret;
  assign app_rd_data_end_o     = rd_ret;
  assign app_rd_data_o         = rd_dat_q[rd_latency_p-1];
  assign init_calib_complete_o = init_calib_q;
  assign error_o               = error_q;

  // Controller FSM: calibration walk, then READY with periodic REFRESH stalls measured start to start.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= e_calib;
      calib_cnt_q   <= '0;
      refresh_cnt_q <= '0;
      init_calib_q  <= 1'b0;
    end else begin
      case (state_q)
        e_calib: begin
          calib_cnt_q <= calib_cnt_q + 1'b1;
          if (calib_cnt_q == calib_last_lp) begin
            state_q       <= e_ready;
            init_calib_q  <= 1'b1;
            refresh_cnt_q <= '0;
          end
        end
        e_ready: begin
          if (refresh_cnt_q == ref_period_m1_lp) begin
            state_q       <= e_refresh;
            refresh_cnt_q <= '0;
          end else begin
            refresh_cnt_q <= refresh_cnt_q + 1'b1;
          end
        end
        e_refresh: begin
          refresh_cnt_q <= refresh_cnt_q + 1'b1;
          if (refresh_cnt_q == ref_cycles_m1_lp) begin
            state_q <= e_ready;
          end
        end
        default: begin
          state_q      <= e_calib;
          calib_cnt_q  <= '0;
          init_calib_q <= 1'b0;
        end
      endcase
    end
  end

  // Array writes: zero fill during CALIB, otherwise byte-masked accepted writes.
  always_ff @(posedge clk_i) begin
    if (state_q == e_calib) begin
      mem_q[calib_cnt_q] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < mask_width_lp; b++) begin
        if (!app_wdf_mask_i[b]) begin
          mem_q[blk_idx][8*b +: 8] <= app_wdf_data_i[8*b +: 8];
        end
      end
    end
  end

  // Outstanding-read credits: accept and return in the same cycle cancel out.
  always_comb begin
    rd_out_d = rd_out_q;
    if (rd_acc && !rd_ret) begin
      rd_out_d = rd_out_q + 1'b1;
    end else if (!rd_acc && rd_ret) begin
      rd_out_d = rd_out_q - 1'b1;
    end
  end

  // Sticky protocol error: data beat without a write command, write command without data,
  // mismatched end flag, or an unknown command that was accepted.
  always_comb begin
    error_d = error_q;
    if ((wr_cmd_acc && !(app_wdf_wren_i && app_wdf_end_i))
        || (app_wdf_wren_i && !wr_cmd_acc)
        || (app_wdf_wren_i != app_wdf_end_i)
        || bad_cmd_acc) begin
      error_d = 1'b1;
    end
  end

  // Read return pipe, credit count and error flag; reset discards anything in flight.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_vld_q <= '0;
      rd_dat_q <= '0;
      rd_out_q <= '0;
      error_q  <= 1'b0;
    end else begin
      rd_vld_q[0] <= rd_acc;
      rd_dat_q[0] <= rd_acc ? mem_rd_dat : '0;
      for (int s = 1; s < rd_latency_p; s++) begin
        rd_vld_q[s] <= rd_vld_q[s-1];
        rd_dat_q[s] <= rd_dat_q[s-1];
      end
      rd_out_q <= rd_out_d;
      error_q  <= error_d;
    end
  end

endmodule

// File: tb/tb_bp_xui_mem_model.sv
// Directed bench for bp_xui_mem_model: calibration timing, masked writes, read latency,
// credit-limited read bursts, refresh stalls under a continuous write stream, and error/reset handling.
`timescale 1ns/1ps

module tb_bp_xui_mem_model;

  logic         clk;
  logic         rst_n;
  logic [39:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic         wdf_wren;
  logic [511:0] wdf_data;
  logic [63:0]  wdf_mask;
  logic         wdf_end;
  logic         wdf_rdy;
  logic         rd_vld;
  logic [511:0] rd_dat;
  logic         rd_end;
  logic         calib_done;
  logic         err;

  int checks = 0;
  int errors = 0;

  bp_xui_mem_model dut (
    .clk_i                 (clk),
    .reset_n_i             (rst_n),
    .app_addr_i            (app_addr),
    .app_cmd_i             (app_cmd),
    .app_en_i              (app_en),
    .app_rdy_o             (app_rdy),
    .app_wdf_wren_i        (wdf_wren),
    .app_wdf_data_i        (wdf_data),
    .app_wdf_mask_i        (wdf_mask),
    .app_wdf_end_i         (wdf_end),
    .app_wdf_rdy_o         (wdf_rdy),
    .app_rd_data_valid_o   (rd_vld),
    .app_rd_data_o         (rd_dat),
    .app_rd_data_end_o     (rd_end),
    .init_calib_complete_o (calib_done),
    .error_o               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  typedef struct {
    logic         is_wr;
    logic [39:0]  addr;
    logic [511:0] dat;
    logic [63:0]  mask;
    logic [511:0] exp;
    string        name;
  } vec_t;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    app_en   = 1'b0;
    app_cmd  = 3'b000;
    wdf_wren = 1'b0;
    wdf_end  = 1'b0;
    wdf_mask = '0;
  endtask

  function automatic logic [511:0] burst_dat(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {16{w}};
  endfunction

  function automatic logic [511:0] wr_dat(input int k);
    logic [31:0] w;
    w = 32'hF00D_0000 + 32'(k);
    return {16{w}};
  endfunction

  task automatic do_write(input logic [39:0] a, input logic [511:0] d, input logic [63:0] m);
    app_en   = 1'b1;
    app_cmd  = 3'b000;
    app_addr = a;
    wdf_wren = 1'b1;
    wdf_end  = 1'b1;
    wdf_data = d;
    wdf_mask = m;
    tick();
    idle();
  endtask

  // One read: checks the return latency, data and end flag.
  task automatic do_read(input string nm, input logic [39:0] a, input logic [511:0] exp);
    int lat;
    app_en   = 1'b1;
    app_cmd  = 3'b001;
    app_addr = a;
    tick();
    idle();
    lat = 1;
    while (!rd_vld && lat < 20) begin
      tick();
      lat++;
    end
    check({nm, "_latency"}, 512'(lat), 512'(4));
    check({nm, "_data"}, rd_dat, exp);
    check({nm, "_end"}, 512'(rd_end), 512'(1));
    tick();
  endtask

  // Leaves the bench at the first READY cycle after a refresh stall.
  task automatic sync_refresh();
    int  n;
    logic saw_low;
    n = 0;
    saw_low = 1'b0;
    while (wdf_rdy && n < 200) begin
      tick();
      n++;
    end
    while (!wdf_rdy && n < 300) begin
      saw_low = 1'b1;
      tick();
      n++;
    end
    check("sync_refresh", 512'(saw_low & wdf_rdy), 512'(1));
  endtask

  // Releases reset and counts cycles to the first ready; flags any read return on the way.
  task automatic release_and_calibrate(input string nm);
    int   n;
    logic saw_vld;
    rst_n = 1'b1;
    n = 0;
    saw_vld = 1'b0;
    while (!app_rdy && n < 400) begin
      tick();
      n++;
      if (rd_vld) saw_vld = 1'b1;
    end
    check({nm, "_calib_cycles"}, 512'(n), 512'(256));
    check({nm, "_calib_done"}, 512'(calib_done), 512'(1));
    check({nm, "_no_rd_valid"}, 512'(saw_vld), 512'(0));
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_app_rdy"}, 512'(app_rdy), 512'(0));
    check({nm, "_wdf_rdy"}, 512'(wdf_rdy), 512'(0));
    check({nm, "_rd_valid"}, 512'(rd_vld), 512'(0));
    check({nm, "_rd_data"}, rd_dat, 512'(0));
    check({nm, "_calib"}, 512'(calib_done), 512'(0));
    check({nm, "_error"}, 512'(err), 512'(0));
  endtask

  vec_t vecs[9];
  int   exp_acc[10];

  initial begin
    vecs[0] = '{1'b1, 40'h40,          {8{64'hDEAD_BEEF_0123_4567}}, 64'h0,                   512'h0,                        "wr_0x40"};
    vecs[1] = '{1'b0, 40'h40,          512'h0,                       64'h0,                   {8{64'hDEAD_BEEF_0123_4567}}, "rd_0x40"};
    vecs[2] = '{1'b1, 40'h0,           {512{1'b1}},                  64'h0,                   512'h0,                        "wr_ones_0x00"};
    vecs[3] = '{1'b1, 40'h0,           512'h0,                       64'hFFFF_FFFF_FFFF_FFFE, 512'h0,                        "wr_byte0_0x00"};
    vecs[4] = '{1'b0, 40'h0,           512'h0,                       64'h0,                   {{504{1'b1}}, 8'h00},          "rd_masked_0x00"};
    vecs[5] = '{1'b0, 40'h10_0000_4055, 512'h0,                      64'h0,                   {8{64'hDEAD_BEEF_0123_4567}}, "rd_alias_0x40"};
    vecs[6] = '{1'b1, 40'h1FC0,        {64{8'hA5}},                  64'h0000_0000_0000_00FF, 512'h0,                        "wr_part_0x1fc0"};
    vecs[7] = '{1'b0, 40'h1FC0,        512'h0,                       64'h0,                   {{56{8'hA5}}, 64'h0},          "rd_part_0x1fc0"};
    vecs[8] = '{1'b0, 40'h3FC0,        512'h0,                       64'h0,                   512'h0,                        "rd_last_zero"};
    exp_acc = '{0, 1, 5, 6, 10, 11, 15, 16, 20, 21};

    rst_n    = 1'b0;
    app_addr = '0;
    wdf_data = '0;
    idle();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    release_and_calibrate("boot");
    do_read("rd_0x80_zero", 40'h80, 512'h0);

    // Table-driven write/read vectors, all inside one refresh-free window.
    sync_refresh();
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].dat, vecs[i].mask);
      end else begin
        do_read(vecs[i].name, vecs[i].addr, vecs[i].exp);
      end
    end

    // Credit-limited read burst with en held high.
    sync_refresh();
    for (int i = 0; i < 10; i++) do_write(40'((16 + i) * 64), burst_dat(i), 64'h0);
    begin
      int acc_n;
      int ret_n;
      acc_n    = 0;
      ret_n    = 0;
      app_en   = 1'b1;
      app_cmd  = 3'b001;
      app_addr = 40'(16 * 64);
      for (int cyc = 0; cyc < 40; cyc++) begin
        if (rd_vld) begin
          if (ret_n < 10) begin
            check("burst_ret_data", rd_dat, burst_dat(ret_n));
            check("burst_ret_cycle", 512'(cyc), 512'(exp_acc[ret_n] + 4));
          end
          ret_n++;
        end
        if (app_en && app_rdy) begin
          if (acc_n < 10) check("burst_acc_cycle", 512'(cyc), 512'(exp_acc[acc_n]));
          acc_n++;
        end
        tick();
        app_en   = (acc_n < 10);
        app_addr = 40'((16 + acc_n) * 64);
      end
      idle();
      check("burst_acc_count", 512'(acc_n), 512'(10));
      check("burst_ret_count", 512'(ret_n), 512'(10));
    end

    // Continuous write stream across three refresh stalls.
    sync_refresh();
    begin
      int nacc;
      int bad;
      nacc = 0;
      bad  = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
        app_en   = 1'b1;
        app_cmd  = 3'b000;
        wdf_wren = wdf_rdy;
        wdf_end  = wdf_rdy;
        app_addr = 40'(nacc * 64);
        wdf_data = wr_dat(nacc);
        wdf_mask = '0;
        if (app_rdy !== ((cyc % 64) < 60)) bad++;
        if (app_rdy) nacc++;
        tick();
      end
      idle();
      check("stream_rdy_pattern_mismatches", 512'(bad), 512'(0));
      check("stream_accepts", 512'(nacc), 512'(188));
      check("stream_no_error", 512'(err), 512'(0));
    end
    do_read("stream_rd_0", 40'h0, wr_dat(0));
    do_read("stream_rd_100", 40'(100 * 64), wr_dat(100));
    do_read("stream_rd_187", 40'(187 * 64), wr_dat(187));

    // WR command without write data: error sets, sticks, and the array is untouched.
    sync_refresh();
    app_en   = 1'b1;
    app_cmd  = 3'b000;
    app_addr = 40'(5 * 64);
    wdf_data = {64{8'h55}};
    wdf_wren = 1'b0;
    wdf_end  = 1'b0;
    tick();
    idle();
    check("err_set", 512'(err), 512'(1));
    repeat (3) tick();
    check("err_sticky", 512'(err), 512'(1));
    do_read("err_array_unchanged", 40'(5 * 64), wr_dat(5));

    // Reset while a read is in flight: the return is discarded and the array re-zeroed.
    app_en   = 1'b1;
    app_cmd  = 3'b001;
    app_addr = 40'(5 * 64);
    tick();
    idle();
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick();
    release_and_calibrate("midreset");
    do_read("midreset_rezeroed", 40'(5 * 64), 512'h0);

    // Accepted illegal command encoding.
    app_en   = 1'b1;
    app_cmd  = 3'b111;
    app_addr = 40'h0;
    tick();
    idle();
    check("illegal_cmd_err", 512'(err), 512'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_xui_mem_model.md
# bp_xui_mem_model

Behavioral DRAM-controller model for the Xilinx user interface (XUI/MIG "app_*" port), sitting directly downstream of the CCE-memory-to-XUI converter in `bp_me/test/common` testbenches. It accepts one XUI command per cycle and stores full blocks in an internal array. It returns read data after a fixed latency and emulates calibration and periodic refresh stalls by dropping `app_rdy_o`/`app_wdf_rdy_o`. This exercises the upstream converter's backpressure handling.

## Interface
- `addr_width_p`, 40: width of `app_addr_i` (byte address).
- `data_width_p`, 512: block width; must be a power of two, at least 64.
- `mem_els_p`, 256: number of blocks stored; must be a power of two.
- `rd_latency_p`, 4: cycles from read accept to `app_rd_data_valid_o`; at least 1.
- `max_rd_outstanding_p`, 2: read-credit cap; 1 to `rd_latency_p`.
- `refresh_period_p`, 64: cycles between refresh starts, counted in READY/REFRESH.
- `refresh_cycles_p`, 4: refresh stall length; must be less than `refresh_period_p`.
- `clk_i` in 1: single clock; all logic is posedge.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `app_addr_i` in `addr_width_p`: command byte address.
- `app_cmd_i` in 3: `app_cmd_e`; RD=3'b001, WR=3'b000; other encodings are ignored but flag an error.
- `app_en_i` in 1: command valid. A command is accepted when `app_en_i` and `app_rdy_o` are both high.
- `app_rdy_o` out 1: command ready.
- `app_wdf_wren_i` in 1: write data valid.
- `app_wdf_data_i` in `data_width_p`: write data.
- `app_wdf_mask_i` in `data_width_p/8`: byte mask; 1 means the byte is NOT written.
- `app_wdf_end_i` in 1: last beat; must equal `app_wdf_wren_i` (single-beat).
- `app_wdf_rdy_o` out 1: write data ready.
- `app_rd_data_valid_o` out 1: read return valid; no backpressure.
- `app_rd_data_o` out `data_width_p`: read data.
- `app_rd_data_end_o` out 1: equals `app_rd_data_valid_o`.
- `init_calib_complete_o` out 1: calibration done.
- `error_o` out 1: sticky protocol error.

## Operation
- Index = `app_addr_i[lg(data_width_p/8) +: lg(mem_els_p)]`. Upper bits and sub-block bits are ignored.
- FSM states:
  - CALIB (reset state): a counter walks index 0 to `mem_els_p-1`, writing zero, one entry per cycle. After the last entry, go to READY.
  - READY: normal operation. When the refresh counter reaches `refresh_period_p-1`, go to REFRESH and clear the refresh counter.
  - REFRESH: lasts `refresh_cycles_p` cycles, then returns to READY. The refresh counter keeps counting through REFRESH, so the refresh period is measured start to start.
- `app_rdy_o` = (state==READY) & (rd_outstanding < `max_rd_outstanding_p`).
- `app_wdf_rdy_o` = (state==READY).
- Write accept: requires `app_en_i`, `app_rdy_o`, `app_cmd_i`==WR, `app_wdf_wren_i` and `app_wdf_end_i` all in the same cycle. Each unmasked byte is written at the clock edge.
- A WR accept without `app_wdf_wren_i`, or `app_wdf_wren_i` without a WR accept:
  - set `error_o`;
  - drop the write.
- Read accept: the array is read combinationally at accept, so a write accepted in cycle t is visible to a read accepted in cycle t+1 or later. The data is pushed into an `rd_latency_p`-stage valid+data shift register.
- rd_outstanding:
  - increments on read accept;
  - decrements when the last stage is valid;
  - both in the same cycle means no change.
- An illegal `app_cmd_i` that is accepted sets `error_o`; no other effect.
- Array contents are not touched by reset except through CALIB.
- `init_calib_complete_o` is registered: high in every state except CALIB.

## Timing
- Reset values: state=CALIB, all counters 0, pipe valids 0.
- Output values while reset is asserted: `app_rdy_o`=0, `app_wdf_rdy_o`=0, `app_rd_data_valid_o`=0, `app_rd_data_o`=0, `init_calib_complete_o`=0, `error_o`=0.
- Reset mid-operation: in-flight reads are discarded, with no valid pulse, and CALIB re-zeroes the array.
- After reset deasserts, `init_calib_complete_o` and `app_rdy_o` first rise exactly `mem_els_p` cycles later.
- Read accepted at edge t: `app_rd_data_valid_o` is high during cycle t+`rd_latency_p`, for exactly one cycle. Returns are strictly in order.
- Back-to-back reads are accepted every cycle until the credit cap is hit.
  - At the cap, `app_rdy_o` is low until the cycle after a return.
  - A return and a new accept may occur in the same cycle.
- Reads already in the pipe complete during REFRESH.
- `app_rdy_o` and `app_wdf_rdy_o` depend only on registered state, with no combinational path from inputs.

## Test plan
- Reset, then idle:
  - `app_rdy_o` stays 0 for exactly 256 cycles, then rises with `init_calib_complete_o`.
  - A read of addr 0x80 then returns 512'h0.
- Write addr 0x40 with data = {8{64'hDEAD_BEEF_0123_4567}} and mask 0, then read 0x40 on the next cycle:
  - valid appears 4 cycles after the read accept;
  - the data matches;
  - `app_rd_data_end_o`=1.
- Write all-ones to 0x00, then write 0 to 0x00 with mask = 64'hFFFF_FFFF_FFFF_FFFE. A read of 0x00 returns all-ones except byte 0 = 8'h00.
- Hold `app_en_i`=1 with RD for 10 cycles:
  - with cap 2, accepts occur in the pattern 2 accepted, stall, 1 accepted per return;
  - no accept occurs while rd_outstanding==2;
  - 10 returns arrive in order.
- Hold `app_en_i`=1 with WR for 200 cycles after calibration:
  - `app_rdy_o` drops for exactly 4 cycles every 64 cycles;
  - no write is lost.
- Issue WR with `app_wdf_wren_i`=0: `error_o` rises and stays set, and the array is unchanged. Assert reset mid-read: no `app_rd_data_valid_o` pulse follows.
